// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//   Stall/flush sequencer for the 5-stage F/D/E/M/W pipeline. Resolves
//   load-use hazards, taken branches/jumps and multi-cycle data-memory
//   accesses. Keeps saturating stall/redirect counters and a sticky
//   memory-timeout flag.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   Rs1D_i, Rs2D_i              source registers of the instruction in D
//   RdE_i, RegWriteE_i,
//   ResultSrcE_i                destination/write-enable/load flag in E
//   PCSrcE_i                    branch taken or jump resolved in E
//   MemAccessM_i, MemReadyM_i   memory access present in M / completes now
//   StallF_o..StallM_o          hold PC, F/D, D/E, E/M registers
//   FlushD_o, FlushE_o, FlushW_o bubble into F/D, D/E, M/W registers
//   StallCycles_o               cycles with StallF_o=1 (saturating)
//   FlushCount_o                redirects applied (saturating)
//   MemTimeout_o                sticky: a memory wait reached MAX_WAIT
module pipeline_hazard_controller #(
  parameter int CNT_WIDTH  = 32,
  parameter int MAX_WAIT   = 255,
  parameter int WAIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           Rs1D_i,
  input  logic [4:0]           Rs2D_i,
  input  logic [4:0]           RdE_i,
  input  logic                 RegWriteE_i,
  input  logic                 ResultSrcE_i,
  input  logic                 PCSrcE_i,
  input  logic                 MemAccessM_i,
  input  logic                 MemReadyM_i,
  output logic                 StallF_o,
  output logic                 StallD_o,
  output logic                 StallE_o,
  output logic                 StallM_o,
  output logic                 FlushD_o,
  output logic                 FlushE_o,
  output logic                 FlushW_o,
  output logic [CNT_WIDTH-1:0] StallCycles_o,
  output logic [CNT_WIDTH-1:0] FlushCount_o,
  output logic                 MemTimeout_o
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [WAIT_WIDTH-1:0] WAIT_MAX = WAIT_WIDTH'(MAX_WAIT);
  localparam logic [WAIT_WIDTH-1:0] WAIT_ONE = WAIT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

  state_t                state, state_nxt;
  logic [WAIT_WIDTH-1:0] wait_cnt, wait_nxt;
  logic                  set_timeout;
  logic                  memwait, loaduse, redirect, redirect_act;

  assign memwait  = MemAccessM_i & ~MemReadyM_i;
  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign loaduse  = ResultSrcE_i & RegWriteE_i & (RdE_i != 5'd0) &
                    ((RdE_i == Rs1D_i) | (RdE_i == Rs2D_i));
  assign redirect = PCSrcE_i;
  // A redirect only takes effect when the pipe is not frozen by memory
  assign redirect_act = rst_n & redirect & ~memwait;

  always_comb begin
    StallF_o = 1'b0;
    StallD_o = 1'b0;
    StallE_o = 1'b0;
    StallM_o = 1'b0;
    FlushD_o = 1'b0;
    FlushE_o = 1'b0;
    FlushW_o = 1'b0;
    if (!rst_n) begin
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
      FlushW_o = 1'b1;
    end else if (memwait) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      StallE_o = 1'b1;
      StallM_o = 1'b1;
      FlushW_o = 1'b1;
    end else if (redirect) begin
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
    end else if (loaduse) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      FlushE_o = 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    set_timeout = 1'b0;
    unique case (state)
      RUN: begin
        if (memwait) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WAIT_ONE;
        end
      end
      MEM_WAIT: begin
        if (memwait) begin
          if (wait_cnt == WAIT_MAX) set_timeout = 1'b1;
          else                      wait_nxt    = wait_cnt + WAIT_ONE;
        end else begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= RUN;
      wait_cnt      <= '0;
      StallCycles_o <= '0;
      FlushCount_o  <= '0;
      MemTimeout_o  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (set_timeout) MemTimeout_o <= 1'b1;
      if (StallF_o && (StallCycles_o != '1))
        StallCycles_o <= StallCycles_o + CNT_ONE;
      if (redirect_act && (FlushCount_o != '1))
        FlushCount_o <= FlushCount_o + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

  localparam int CW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    rs1, rs2, rd;
  logic          regwrite, resultsrc, pcsrc, memaccess, memready;
  logic          stall_f, stall_d, stall_e, stall_m;
  logic          flush_d, flush_e, flush_w;
  logic [CW-1:0] stall_cycles, flush_count;
  logic          mem_timeout;

  int errors = 0;
  int checks = 0;

  // reference model state
  longint m_stall_cnt, m_flush_cnt;
  int     m_wait;      // cycles the current access has been waiting, 0 = none
  bit     m_timeout;
  longint cnt_max;

  pipeline_hazard_controller #(.CNT_WIDTH(CW), .MAX_WAIT(MW), .WAIT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D_i(rs1), .Rs2D_i(rs2), .RdE_i(rd),
    .RegWriteE_i(regwrite), .ResultSrcE_i(resultsrc), .PCSrcE_i(pcsrc),
    .MemAccessM_i(memaccess), .MemReadyM_i(memready),
    .StallF_o(stall_f), .StallD_o(stall_d), .StallE_o(stall_e), .StallM_o(stall_m),
    .FlushD_o(flush_d), .FlushE_o(flush_e), .FlushW_o(flush_w),
    .StallCycles_o(stall_cycles), .FlushCount_o(flush_count),
    .MemTimeout_o(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, then advance
  // the model across the rising edge.
  task automatic cyc(input bit r, input int s1, input int s2, input int d,
                     input bit rw, input bit ld, input bit pc,
                     input bit acc, input bit rdy);
    bit       mw, lu, sf;
    bit [6:0] exp;
    rst_n = r; rs1 = 5'(s1); rs2 = 5'(s2); rd = 5'(d);
    regwrite = rw; resultsrc = ld; pcsrc = pc;
    memaccess = acc; memready = rdy;
    #3;
    mw = acc && !rdy;
    lu = ld && rw && d != 0 && (d == s1 || d == s2);
    // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    if (!r)       exp = 7'b0000_111;
    else if (mw)  exp = 7'b1111_001;
    else if (pc)  exp = 7'b0000_110;
    else if (lu)  exp = 7'b1100_010;
    else          exp = 7'b0000_000;
    check("ctrl", {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}, exp);
    check("stall_cycles", stall_cycles, m_stall_cnt);
    check("flush_count", flush_count, m_flush_cnt);
    check("timeout", mem_timeout, m_timeout);
    sf = exp[6];
    @(posedge clk);
    if (!r) begin
      m_stall_cnt = 0; m_flush_cnt = 0; m_wait = 0; m_timeout = 0;
    end else begin
      if (mw) begin
        if (m_wait == MW) m_timeout = 1;
        m_wait = (m_wait == 0) ? 1 : ((m_wait + 1 > MW) ? MW : m_wait + 1);
      end else begin
        m_wait = 0;
      end
      if (sf && m_stall_cnt < cnt_max) m_stall_cnt++;
      if (pc && !mw && m_flush_cnt < cnt_max) m_flush_cnt++;
    end
    #1;
  endtask

  task automatic idle(input bit r);
    cyc(r, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cnt_max = (64'd1 << CW) - 1;
    m_stall_cnt = 0; m_flush_cnt = 0; m_wait = 0; m_timeout = 0;
    rst_n = 0; rs1 = 0; rs2 = 0; rd = 0; regwrite = 0; resultsrc = 0;
    pcsrc = 0; memaccess = 0; memready = 0;
    @(posedge clk); #1;

    // reset state
    idle(0); idle(0);
    check("rst_stall_cycles", stall_cycles, 0);
    check("rst_timeout", mem_timeout, 0);

    // load-use: lw x5 in E, Rs1D=5, then load moves on
    cyc(1, 5, 7, 5, 1, 1, 0, 0, 0);
    idle(1);
    check("lu_stall_cycles", stall_cycles, 1);

    // x0 load never stalls
    idle(0);
    cyc(1, 0, 3, 0, 1, 1, 0, 0, 0);
    check("x0_stall_cycles", stall_cycles, 0);

    // branch together with load-use: redirect wins
    cyc(1, 6, 6, 6, 1, 1, 1, 0, 0);
    idle(1);
    check("br_lu_flush_count", flush_count, 1);
    check("br_lu_stall_cycles", stall_cycles, 0);

    // memory wait of 3 cycles
    idle(0);
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    check("mw_stall_cycles", stall_cycles, 3);

    // zero-wait access: no stall
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    check("zw_stall_cycles", stall_cycles, 3);

    // timeout with branch pending in E during the wait
    idle(0);
    repeat (5) cyc(1, 0, 0, 0, 0, 0, 1, 1, 0);
    check("to_after5", mem_timeout, 1);
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(1);
    check("to_sticky", mem_timeout, 1);
    check("to_flush_count", flush_count, 1);
    check("to_stall_cycles", stall_cycles, 6);

    // reset mid-wait
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    check("rmw_stall_cycles", stall_cycles, 0);
    check("rmw_timeout", mem_timeout, 0);
    idle(1);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 30) != 0,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          bit'($urandom % 2), bit'($urandom % 2), ($urandom % 4) == 0,
          bit'($urandom % 2), ($urandom % 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
    $fatal(1);
  end

endmodule
